dcache_writeback_buffer: RTL and testbench

- Sits downstream of the dcache way-match/PLRU logic.
- When a line fill evicts a dirty way (writeback_needed), the dcache pushes the victim line (20-bit tag, 128-bit data) plus its 8-bit set index into this buffer.
- The buffer drains entries in FIFO order as 4-beat 32-bit Avalon-MM write bursts to memory.
- A snoop port lets the dcache detect, and optionally forward, a pending victim before re-reading the same line from memory.

---
 rtl/dcache_writeback_buffer.sv | 165 ++++++++++++++++
 tb/tb_dcache_writeback_buffer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_writeback_buffer.sv
// Victim-line write-back FIFO: drains dirty lines as 4-beat 32-bit Avalon-MM write bursts.
// Define DCACHE_WB_FORWARD_EN to forward the newest matching pending line on snoop_data.
module dcache_writeback_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wb_push,
  input  logic [19:0]  wb_tag,
  input  logic [7:0]   wb_set,
  input  logic [127:0] wb_line,
  output logic         wb_full,
  output logic         wb_empty,
  input  logic [27:0]  snoop_address,
  output logic         snoop_hit,
  output logic [127:0] snoop_data,
  output logic [29:0]  avm_address,
  output logic [31:0]  avm_writedata,
  output logic [3:0]   avm_byteenable,
  output logic [2:0]   avm_burstcount,
  output logic         avm_write,
  input  logic         avm_waitrequest
);

  typedef enum logic {IDLE, BURST} state_e;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [19:0]      tag_q  [DEPTH];
  logic [7:0]       set_q  [DEPTH];
  logic [127:0]     line_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [1:0]       beat_q, beat_d;
  state_e           state_q, state_d;
  logic             wb_full_q, wb_full_d;
  logic             wb_empty_q, wb_empty_d;
  logic             push_ok;
  logic             beat_acc;
  logic             pop;

  // A full buffer refuses pushes even when the head entry retires this same cycle.
  assign push_ok  = wb_push && !wb_full_q;
  assign beat_acc = (state_q == BURST) && !avm_waitrequest;
  assign pop      = beat_acc && (beat_q == 2'd3);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;

    case (state_q)
      IDLE: begin
        if (!wb_empty_q) state_d = BURST;
      end
      BURST: begin
        if (beat_acc) begin
          beat_d = beat_q + 2'd1;
          if (pop) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    if (push_ok) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end

    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    wb_full_d  = (count_d == FULL_CNT);
    wb_empty_d = (count_d == '0);
  end

  // NOTE: the payload arrays carry no reset; valid_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      tag_q[wr_ptr_q]  <= wb_tag;
      set_q[wr_ptr_q]  <= wb_set;
      line_q[wr_ptr_q] <= wb_line;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_q     <= 2'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      wb_full_q  <= 1'b0;
      wb_empty_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      wb_full_q  <= wb_full_d;
      wb_empty_q <= wb_empty_d;
    end
  end

  assign wb_full        = wb_full_q;
  assign wb_empty       = wb_empty_q;
  assign avm_byteenable = 4'hF;

  // Address and data come straight from the head entry, so they stay put under waitrequest.
  always_comb begin
    avm_write      = 1'b0;
    avm_address    = '0;
    avm_writedata  = '0;
    avm_burstcount = '0;
    if (state_q == BURST) begin
      avm_write      = 1'b1;
      avm_address    = {tag_q[rd_ptr_q], set_q[rd_ptr_q], 2'b00};
      avm_writedata  = line_q[rd_ptr_q][{beat_q, 5'b0} +: 32];
      avm_burstcount = 3'd4;
    end
  end

  always_comb begin
    snoop_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && ({tag_q[i], set_q[i]} == snoop_address)) snoop_hit = 1'b1;
    end
  end

`ifdef DCACHE_WB_FORWARD_EN
  logic [PTR_W-1:0] age_idx;

  // Walk oldest to newest from rd_ptr so the last match, the newest copy, wins.
  always_comb begin
    snoop_data = '0;
    age_idx    = rd_ptr_q;
    for (int k = 0; k < DEPTH; k++) begin
      age_idx = rd_ptr_q + PTR_W'(k);
      if (valid_q[age_idx] && ({tag_q[age_idx], set_q[age_idx]} == snoop_address))
        snoop_data = line_q[age_idx];
    end
  end
`else
  assign snoop_data = '0;
`endif

endmodule

// File: tb/tb_dcache_writeback_buffer.sv
// Self-checking bench for dcache_writeback_buffer: directed cases plus random traffic
// scored against a queue-based model of the victim FIFO and its Avalon bursts.
module tb_dcache_writeback_buffer;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         wb_push;
  logic [19:0]  wb_tag;
  logic [7:0]   wb_set;
  logic [127:0] wb_line;
  logic         wb_full;
  logic         wb_empty;
  logic [27:0]  snoop_address;
  logic         snoop_hit;
  logic [127:0] snoop_data;
  logic [29:0]  avm_address;
  logic [31:0]  avm_writedata;
  logic [3:0]   avm_byteenable;
  logic [2:0]   avm_burstcount;
  logic         avm_write;
  logic         avm_waitrequest;

  dcache_writeback_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .wb_push         (wb_push),
    .wb_tag          (wb_tag),
    .wb_set          (wb_set),
    .wb_line         (wb_line),
    .wb_full         (wb_full),
    .wb_empty        (wb_empty),
    .snoop_address   (snoop_address),
    .snoop_hit       (snoop_hit),
    .snoop_data      (snoop_data),
    .avm_address     (avm_address),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_burstcount  (avm_burstcount),
    .avm_write       (avm_write),
    .avm_waitrequest (avm_waitrequest)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [19:0]  tag;
    logic [7:0]   set;
    logic [127:0] line;
  } ent_t;

  ent_t mq[$];
  int   beat_m      = 0;
  int   bubble_st   = 0;
  int   pend_at_pop = 0;
  int   total       = 0;
  int   bad         = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: pending victims in push order; a burst retires the head after 4 accepted beats.
  always @(negedge clk) begin : model
    logic         hit;
    logic [127:0] fwd;
    logic [127:0] ln;
    bit           acc;
    bit           was_full;
    int           next_st;
    if (rst) begin
      mq.delete();
      beat_m    = 0;
      bubble_st = 0;
    end else begin
      check("m_empty", wb_empty, mq.size() == 0);
      check("m_full", wb_full, mq.size() == DEPTH);

      hit = 1'b0;
      fwd = '0;
      foreach (mq[i]) begin
        if ({mq[i].tag, mq[i].set} == snoop_address) begin
          hit = 1'b1;
          fwd = mq[i].line;
        end
      end
      check("m_snoop_hit", snoop_hit, hit);
`ifdef DCACHE_WB_FORWARD_EN
      if (hit) check("m_snoop_data", snoop_data, fwd);
`else
      check("m_snoop_data", snoop_data, '0);
`endif

      if (avm_write) begin
        if (mq.size() == 0) begin
          check("m_write_when_empty", avm_write, 1'b0);
        end else begin
          ln = mq[0].line;
          check("m_address", avm_address, {mq[0].tag, mq[0].set, 2'b00});
          check("m_writedata", avm_writedata, ln[beat_m*32 +: 32]);
          check("m_burstcount", avm_burstcount, 3'd4);
          check("m_byteenable", avm_byteenable, 4'hF);
        end
      end

      if (bubble_st == 1) check("m_bubble", avm_write, 1'b0);
      else if (bubble_st == 2 && pend_at_pop != 0) check("m_restart", avm_write, 1'b1);

      next_st  = (bubble_st == 1) ? 2 : 0;
      acc      = avm_write && !avm_waitrequest;
      was_full = (mq.size() == DEPTH);
      if (acc && mq.size() != 0) begin
        beat_m++;
        if (beat_m == 4) begin
          void'(mq.pop_front());
          beat_m      = 0;
          next_st     = 1;
          pend_at_pop = mq.size();
        end
      end
      if (wb_push && !was_full) mq.push_back({wb_tag, wb_set, wb_line});
      bubble_st = next_st;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [19:0] t, input logic [7:0] s, input logic [127:0] l);
    wb_push = 1'b1;
    wb_tag  = t;
    wb_set  = s;
    wb_line = l;
    tick();
    wb_push = 1'b0;
  endtask

  task automatic wait_write(input string tag);
    int n = 0;
    @(negedge clk);
    while (!avm_write && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, avm_write, 1'b1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    tick();
    avm_waitrequest = 1'b0;
    wb_push         = 1'b0;
    while ((mq.size() != 0 || avm_write) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, mq.size(), 0);
    tick();
  endtask

  localparam logic [127:0] LINE_T = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] LINE_A = 128'hAAAAAAAA_A5A5A5A5_0A0A0A0A_AAAA0001;
  localparam logic [127:0] LINE_B = 128'hBBBBBBBB_B5B5B5B5_0B0B0B0B_BBBB0002;

  initial begin
    rst             = 1'b1;
    wb_push         = 1'b0;
    wb_tag          = '0;
    wb_set          = '0;
    wb_line         = '0;
    snoop_address   = '0;
    avm_waitrequest = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (10) tick();

    // Reset state after idling
    @(negedge clk);
    check("rst_empty", wb_empty, 1'b1);
    check("rst_full", wb_full, 1'b0);
    check("rst_write", avm_write, 1'b0);
    check("rst_hit", snoop_hit, 1'b0);
    tick();

    // Single burst, no stalls
    push(20'hABCDE, 8'h12, LINE_T);
    wait_write("t2_start");
    check("t2_addr", avm_address, 30'h2AF37848);
    check("t2_beat0", avm_writedata, 32'h11111111);
    @(negedge clk);
    check("t2_beat1", avm_writedata, 32'h22222222);
    @(negedge clk);
    check("t2_beat2", avm_writedata, 32'h33333333);
    @(negedge clk);
    check("t2_beat3", avm_writedata, 32'h44444444);
    check("t2_addr_held", avm_address, 30'h2AF37848);
    @(negedge clk);
    check("t2_idle", avm_write, 1'b0);
    check("t2_empty", wb_empty, 1'b1);
    tick();

    // Three stall cycles on beat 1
    push(20'hABCDE, 8'h12, LINE_T);
    wait_write("t3_start");
    check("t3_beat0", avm_writedata, 32'h11111111);
    tick();
    avm_waitrequest = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t3_stall_data", avm_writedata, 32'h22222222);
      check("t3_stall_addr", avm_address, 30'h2AF37848);
      tick();
    end
    avm_waitrequest = 1'b0;
    @(negedge clk);
    check("t3_beat1", avm_writedata, 32'h22222222);
    @(negedge clk);
    check("t3_beat2", avm_writedata, 32'h33333333);
    @(negedge clk);
    check("t3_beat3", avm_writedata, 32'h44444444);
    drain("t3_drain");

    // Fill to DEPTH under stall, fifth push dropped, then ordered drain
    avm_waitrequest = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++)
      push(20'h10000 + 20'(i), 8'(i), {$urandom, $urandom, $urandom, $urandom});
    @(negedge clk);
    check("t4_full", wb_full, 1'b1);
    check("t4_model_depth", mq.size(), DEPTH);
    drain("t4_drain");
    @(negedge clk);
    check("t4_empty", wb_empty, 1'b1);
    tick();

    // Snoop hits the bursting entry until its last beat is accepted
    avm_waitrequest = 1'b1;
    snoop_address   = 28'hABCDE12;
    push(20'hABCDE, 8'h12, LINE_T);
    wait_write("t5_start");
    check("t5_hit_mid", snoop_hit, 1'b1);
    tick();
    avm_waitrequest = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_hit_beat3", snoop_hit, 1'b1);
    @(negedge clk);
    check("t5_hit_after", snoop_hit, 1'b0);
    drain("t5_drain");

    // Two copies of one line: newest forwarded when enabled
    avm_waitrequest = 1'b1;
    push(20'h12345, 8'h67, LINE_A);
    push(20'h12345, 8'h67, LINE_B);
    snoop_address = 28'h1234567;
    @(negedge clk);
    check("t6_hit", snoop_hit, 1'b1);
`ifdef DCACHE_WB_FORWARD_EN
    check("t6_fwd", snoop_data, LINE_B);
`else
    check("t6_fwd", snoop_data, 128'd0);
`endif
    drain("t6_drain");

    // Reset in the middle of a burst discards everything
    avm_waitrequest = 1'b1;
    snoop_address   = 28'hABCDE12;
    push(20'hABCDE, 8'h12, LINE_T);
    push(20'h55555, 8'h66, LINE_A);
    wait_write("t7_start");
    tick();
    rst = 1'b1;
    tick();
    rst             = 1'b0;
    avm_waitrequest = 1'b0;
    @(negedge clk);
    check("t7_write", avm_write, 1'b0);
    check("t7_empty", wb_empty, 1'b1);
    check("t7_hit", snoop_hit, 1'b0);
    tick();

    // Random traffic against the model
    for (int c = 0; c < 800; c++) begin
      wb_push         = ($urandom_range(99) < 35);
      wb_tag          = 20'($urandom_range(3));
      wb_set          = 8'($urandom_range(3));
      wb_line         = {$urandom, $urandom, $urandom, $urandom};
      avm_waitrequest = ($urandom_range(99) < 30);
      if (mq.size() != 0 && $urandom_range(1) == 1)
        snoop_address = {mq[$urandom_range(mq.size() - 1)].tag, mq[$urandom_range(mq.size() - 1)].set};
      else
        snoop_address = {20'($urandom_range(3)), 8'($urandom_range(3))};
      tick();
    end
    drain("rand_drain");
    @(negedge clk);
    check("rand_empty", wb_empty, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
